// File: rtl/my9262_pkg.sv
// my9262_pkg: FSM states, default frame geometry and timeout terminal count for the MY9262 frame feeder
package my9262_pkg;
    localparam int WORDS_DEF  = 32;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;
    localparam int TMO_W_DEF  = 10;
    typedef enum logic [2:0] {IDLE, READ, START, WAIT_BUSY, WAIT_DONE, NEXT, FRAME_END} state_t;
    function automatic int tmo_tc(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/my9262_pingpong_ram.sv
// my9262_pingpong_ram: two-bank frame store; host writes land in the back bank, registered read from the front bank
module my9262_pingpong_ram
    import my9262_pkg::*;
#(
    parameter int WORDS  = WORDS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              front,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2][WORDS];
    always_ff @(posedge clk) begin
        if (wr_en && int'(wr_addr) < WORDS) mem[~front][wr_addr] <= wr_data;
        rd_data <= mem[front][rd_addr];
    end
endmodule

// File: rtl/my9262_frame_feeder.sv
// my9262_frame_feeder: streams a ping-pong buffered grayscale frame word by word to the MY9262 serializer.
// Build option MY9262_TEST_PATTERN_EN adds test_mode, which replaces RAM data with a per-channel pointer ramp.
module my9262_frame_feeder
    import my9262_pkg::*;
#(
    parameter int WORDS  = WORDS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TMO_W  = TMO_W_DEF
) (
    input  logic              CLK_60M,
    input  logic              RST,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    output logic              commit_pending,
    output logic [DATA_W-1:0] my9262_Data,
    output logic              send_start,
    output logic              last_word,
    input  logic              send_finish,
    output logic              frame_done,
    output logic              err_timeout
`ifdef MY9262_TEST_PATTERN_EN
    ,
    input  logic              test_mode
`endif
);
    localparam logic [TMO_W-1:0]  TMO_END = TMO_W'(tmo_tc(TMO_W));
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(WORDS - 1);
    state_t state, state_next;
    logic [TMO_W-1:0] tmo;
    logic [ADDR_W-1:0] ptr;
    logic front;
    logic [DATA_W-1:0] rd_data, word;
    logic timeout, load, swap;

    my9262_pingpong_ram #(.WORDS(WORDS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk(CLK_60M),
        .front(front),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(ptr),
        .rd_data(rd_data)
    );

`ifdef MY9262_TEST_PATTERN_EN
    assign word = test_mode ? DATA_W'(ptr) << (DATA_W - ADDR_W) : rd_data;
`else
    assign word = rd_data;
`endif

    // READ spans two cycles: the entry-cleared tmo tells the address cycle from the data cycle
    assign load       = state == READ && tmo != '0;
    assign timeout    = (state == WAIT_BUSY || state == WAIT_DONE) && tmo == TMO_END;
    assign swap       = state == FRAME_END && commit_pending;
    assign send_start = state == START;
    assign frame_done = state == FRAME_END;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = enable && send_finish ? READ : IDLE;
            READ:      state_next = load ? START : READ;
            START:     state_next = WAIT_BUSY;
            WAIT_BUSY: state_next = timeout ? IDLE : !send_finish ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_next = timeout ? IDLE : send_finish ? NEXT : WAIT_DONE;
            NEXT:      state_next = ptr == LAST ? FRAME_END : READ;
            FRAME_END: state_next = enable ? READ : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_60M) begin
        if (RST) begin
            state          <= IDLE;
            tmo            <= '0;
            ptr            <= '0;
            front          <= 1'b0;
            commit_pending <= 1'b0;
            my9262_Data    <= '0;
            last_word      <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state          <= state_next;
            tmo            <= state_next != state ? '0 : tmo + 1'b1;
            if (state == NEXT) ptr <= ptr == LAST ? '0 : ptr + 1'b1;
            if (timeout) ptr <= '0;
            if (timeout) err_timeout <= 1'b1;
            if (swap) front <= ~front;
            // a commit arriving with the swap itself stays queued for the following frame
            commit_pending <= swap ? commit : commit_pending | commit;
            if (load) my9262_Data <= word;
            if (load) last_word <= ptr == LAST;
        end
    end
endmodule

// File: tb/tb_my9262_frame_feeder.sv
// tb_my9262_frame_feeder: directed frame streaming, commit, swap collision, timeout and reset checks
module tb_my9262_frame_feeder;
    import my9262_pkg::*;
    localparam int BUSY = 40;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, wr_en = 1'b0, commit = 1'b0, send_finish = 1'b1;
    logic [4:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic commit_pending, send_start, last_word, frame_done, err_timeout;
    logic [15:0] my9262_Data;
    logic [15:0] log_d[$];
    bit log_l[$];
    int n_chk = 0, n_pass = 0, n_fd = 0, busy = 0;
    bit hang = 1'b0;

    always #5 clk = ~clk;

    my9262_frame_feeder dut (
        .CLK_60M(clk),
        .RST(rst),
        .enable(enable),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .commit(commit),
        .commit_pending(commit_pending),
        .my9262_Data(my9262_Data),
        .send_start(send_start),
        .last_word(last_word),
        .send_finish(send_finish),
        .frame_done(frame_done),
        .err_timeout(err_timeout)
    );

    // serializer model and word logger
    always @(negedge clk) begin
        if (send_start) begin
            log_d.push_back(my9262_Data);
            log_l.push_back(last_word);
            if (!hang) begin
                send_finish = 1'b0;
                busy = BUSY;
            end
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) send_finish = 1'b1;
        end
        if (frame_done) n_fd++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_d.delete();
        log_l.delete();
    endtask

    // kind 0: frame_done, 1: at least n words logged, 2: err_timeout
    task automatic wait_for(input string tag, input int kind, input int n, input int budget, output int t);
        t = 0;
        while (!(kind == 0 ? frame_done : kind == 1 ? log_d.size() >= n : err_timeout) && t < budget) begin
            tick();
            t++;
        end
        chk({tag, " reached"}, 32'(t < budget), 1);
    endtask

    task automatic check_frame(input string tag, input bit data, input logic [15:0] base, input logic [15:0] w31);
        chk({tag, " words"}, log_d.size(), 32);
        for (int i = 0; i < 32 && i < log_d.size(); i++) begin
            if (data) chk($sformatf("%s w%0d", tag, i), log_d[i], i == 31 ? w31 : base + 16'(i));
            chk($sformatf("%s last%0d", tag, i), log_l[i], i == 31);
        end
    endtask

    task automatic load_back(input logic [15:0] base);
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1;
            wr_addr = 5'(i);
            wr_data = base + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        int t;
        tick(3);
        chk("rst send_start", send_start, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst last_word", last_word, 0);
        chk("rst data", my9262_Data, 0);
        chk("rst err", err_timeout, 0);
        chk("rst pending", commit_pending, 0);
        chk("rst state", dut.state, IDLE);
        rst = 1'b0;
        tick();
        load_back(16'h0100);
        chk("pending set", commit_pending, 1);
        enable = 1'b1;
        // frame A plays the untouched bank 0; the queued swap happens at its end
        wait_for("A fd", 0, 0, 3000, t);
        chk("A pending at FE", commit_pending, 1);
        check_frame("A", 1'b0, 16'h0, 16'h0);
        chk("A fd count", n_fd, 1);
        clear_log();
        tick();
        chk("A pending cleared", commit_pending, 0);
        // frame B: mid-frame reload and commit must not disturb the words in flight
        wait_for("B w10", 1, 10, 1000, t);
        load_back(16'h0200);
        chk("B pending", commit_pending, 1);
        wait_for("B fd", 0, 0, 3000, t);
        chk("B pending at FE", commit_pending, 1);
        check_frame("B", 1'b1, 16'h0100, 16'h011F);
        clear_log();
        tick();
        chk("B pending cleared", commit_pending, 0);
        // frame C: drop enable at word 10, collide a write and a commit with the swap
        wait_for("C w10", 1, 11, 1000, t);
        enable = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wait_for("C fd", 0, 0, 3000, t);
        wr_en = 1'b1;
        wr_addr = 5'd31;
        wr_data = 16'hBEEF;
        commit = 1'b1;
        check_frame("C", 1'b1, 16'h0200, 16'h021F);
        chk("C fd count", n_fd, 3);
        clear_log();
        tick();
        wr_en = 1'b0;
        commit = 1'b0;
        chk("C commit held", commit_pending, 1);
        chk("C idle", dut.state, IDLE);
        tick(60);
        chk("C no send", log_d.size(), 0);
        chk("C still idle", dut.state, IDLE);
        // frame D: bank 1 with the collided write on word 31
        enable = 1'b1;
        wait_for("D fd", 0, 0, 3000, t);
        check_frame("D", 1'b1, 16'h0100, 16'hBEEF);
        clear_log();
        hang = 1'b1;
        tick();
        chk("D pending cleared", commit_pending, 0);
        // frame E: serializer never goes busy
        wait_for("E w0", 1, 1, 100, t);
        wait_for("E err", 2, 0, 1100, t);
        chk("E timeout cycles", t, 1025);
        chk("E idle", dut.state, IDLE);
        chk("E ptr", dut.ptr, 0);
        chk("E err", err_timeout, 1);
        hang = 1'b0;
        clear_log();
        wait_for("E restart", 1, 1, 100, t);
        chk("E restart w0", log_d[0], 16'h0200);
        chk("E err sticky", err_timeout, 1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wait_for("E fd", 0, 0, 3000, t);
        check_frame("E", 1'b1, 16'h0200, 16'h021F);
        clear_log();
        // frame F: reset at word 5 while bank 1 is in front
        wait_for("F w5", 1, 6, 1000, t);
        chk("F w5", log_d[5], 16'h0105);
        rst = 1'b1;
        tick();
        chk("F rst send_start", send_start, 0);
        chk("F rst frame_done", frame_done, 0);
        chk("F rst last_word", last_word, 0);
        chk("F rst data", my9262_Data, 0);
        chk("F rst err", err_timeout, 0);
        chk("F rst pending", commit_pending, 0);
        chk("F rst state", dut.state, IDLE);
        chk("F rst ptr", dut.ptr, 0);
        tick();
        chk("F no send in rst", log_d.size(), 6);
        rst = 1'b0;
        clear_log();
        wait_for("F restart", 1, 1, 200, t);
        chk("F restart w0", log_d[0], 16'h0200);
        chk("F restart last", log_l[0], 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
